cpu_sequencer: RTL and testbench

Control core of the 8-bit bus CPU. It combines four functions:
- a run-gated micro-cycle counter (the clock-enable function);
- a combinational decoder from (opcode, cycle) to a micro-state;
- the decoded one-hot bus control lines;
- the 8-bit adder ALU.

It sits between the instruction register, the A/B registers and the bus drivers. Registers, RAM, PC and tristate buffers are outside this block.

---
 rtl/cpu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Purpose : control core of the 8-bit bus CPU: micro-cycle counter, (opcode, cycle) decode, bus control lines, adder ALU.
// Latency : decode, control lines and ALU are combinational (zero latency); the cycle counter updates on the rising clk edge.
// Backpressure: run=0 freezes the cycle counter; HALT freezes it until reset. Optional SUB opcode: define ALU_SUB_EN.
module cpu_sequencer #(
   parameter int WIDTH = 8,
   parameter int CYC_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic [WIDTH-1:0] alu_out,
   output logic             cout,
   output logic [CYC_W-1:0] cycle,
   output logic [3:0]       state,
   output logic             halted,
   output logic             c_ai,
   output logic             c_ao,
   output logic             c_bi,
   output logic             c_ci,
   output logic             c_co,
   output logic             c_eo,
   output logic             c_ii,
   output logic             c_j,
   output logic             c_mi,
   output logic             c_oi,
   output logic             c_ro,
   output logic             c_zi,
   output logic             c_zo,
   output logic             c_next
);

   typedef enum logic [3:0] {
      ST_FETCH_PC   = 4'd0,
      ST_FETCH_INST = 4'd1,
      ST_FETCH_ARG  = 4'd2,
      ST_LOAD_Z     = 4'd3,
      ST_RAM_A      = 4'd4,
      ST_RAM_B      = 4'd5,
      ST_ALU        = 4'd6,
      ST_OUT_A      = 4'd7,
      ST_JUMP_Z     = 4'd8,
      ST_NEXT       = 4'd9,
      ST_HALT       = 4'd10,
      ST_ALU_SUB    = 4'd11
   } state_t;

   localparam int SW = WIDTH + 1;

   logic [CYC_W-1:0] cycle_q;
   logic [CYC_W-1:0] cycle_d;
   state_t           st;
   int unsigned      cyc_idx;
   logic [SW-1:0]    alu_sum;

   // Decode the micro-state from the live opcode and current cycle; no opcode latch.
   always_comb begin
      st      = ST_NEXT;
      cyc_idx = 32'(cycle_q);
      if (cyc_idx == 0) begin
         st = ST_FETCH_PC;
      end else if (cyc_idx == 1) begin
         st = ST_FETCH_INST;
      end else begin
         case (opcode)
            4'd1: begin
               case (cyc_idx)
                  2:       st = ST_FETCH_PC;
                  3:       st = ST_FETCH_ARG;
                  4:       st = ST_LOAD_Z;
                  5:       st = ST_RAM_A;
                  default: st = ST_NEXT;
               endcase
            end
            4'd2: begin
               case (cyc_idx)
                  2:       st = ST_FETCH_PC;
                  3:       st = ST_FETCH_ARG;
                  4:       st = ST_LOAD_Z;
                  5:       st = ST_RAM_B;
                  6:       st = ST_ALU;
                  default: st = ST_NEXT;
               endcase
            end
            4'd3: begin
               if (cyc_idx == 2) st = ST_OUT_A;
            end
            4'd4: begin
               case (cyc_idx)
                  2:       st = ST_FETCH_PC;
                  3:       st = ST_JUMP_Z;
                  default: st = ST_NEXT;
               endcase
            end
`ifdef ALU_SUB_EN
            4'd5: begin
               case (cyc_idx)
                  2:       st = ST_FETCH_PC;
                  3:       st = ST_FETCH_ARG;
                  4:       st = ST_LOAD_Z;
                  5:       st = ST_RAM_B;
                  6:       st = ST_ALU_SUB;
                  default: st = ST_NEXT;
               endcase
            end
`endif
            4'd15: begin
               if (cyc_idx == 2) st = ST_HALT;
            end
            default: st = ST_NEXT;
         endcase
      end
   end

   // Next cycle: restart after NEXT, park in HALT, otherwise count (natural wrap).
   always_comb begin
      cycle_d = cycle_q;
      if (run) begin
         if (st == ST_NEXT) begin
            cycle_d = '0;
         end else if (st != ST_HALT) begin
            cycle_d = cycle_q + CYC_W'(1);
         end
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   // Adder ALU; the SUB micro-state turns it into a + ~b + 1, cout=1 meaning no borrow.
   always_comb begin
      alu_sum = {1'b0, a_in} + {1'b0, b_in} + SW'(cin);
`ifdef ALU_SUB_EN
      if (st == ST_ALU_SUB) begin
         alu_sum = {1'b0, a_in} + {1'b0, ~b_in} + SW'(1);
      end
`endif
   end

   assign {cout, alu_out} = alu_sum;
   assign cycle  = cycle_q;
   assign state  = st;
   assign halted = (st == ST_HALT);

   // One-hot bus control lines; only one bus driver (ao/co/eo/ro/zo) is active per state.
   assign c_ai   = (st == ST_RAM_A) || (st == ST_ALU) || (st == ST_ALU_SUB);
   assign c_ao   = (st == ST_OUT_A);
   assign c_bi   = (st == ST_RAM_B);
   assign c_ci   = (st == ST_FETCH_INST) || (st == ST_FETCH_ARG) || (st == ST_JUMP_Z);
   assign c_co   = (st == ST_FETCH_PC);
   assign c_eo   = (st == ST_ALU) || (st == ST_ALU_SUB);
   assign c_ii   = (st == ST_FETCH_INST);
   assign c_j    = (st == ST_JUMP_Z);
   assign c_mi   = (st == ST_FETCH_PC) || (st == ST_LOAD_Z);
   assign c_oi   = (st == ST_OUT_A);
   assign c_ro   = (st == ST_FETCH_INST) || (st == ST_FETCH_ARG) || (st == ST_JUMP_Z) ||
                   (st == ST_RAM_A) || (st == ST_RAM_B);
   assign c_zi   = (st == ST_FETCH_ARG);
   assign c_zo   = (st == ST_LOAD_Z);
   assign c_next = (st == ST_NEXT) || !reset;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed micro-sequences followed by randomized opcode/run/operand traffic.
// Expected values come from per-opcode state lists and arithmetic on the operands.
// Honours ALU_SUB_EN the same way as the design.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic [7:0] a_in = 8'd0;
   logic [7:0] b_in = 8'd0;
   logic       cin = 1'b0;
   logic [7:0] alu_out;
   logic       cout;
   logic [3:0] cycle;
   logic [3:0] state;
   logic       halted;
   logic c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_ii, c_j, c_mi, c_oi, c_ro, c_zi, c_zo, c_next;

   cpu_sequencer #(.WIDTH(8), .CYC_W(4)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode),
      .a_in(a_in), .b_in(b_in), .cin(cin),
      .alu_out(alu_out), .cout(cout), .cycle(cycle), .state(state), .halted(halted),
      .c_ai(c_ai), .c_ao(c_ao), .c_bi(c_bi), .c_ci(c_ci), .c_co(c_co), .c_eo(c_eo),
      .c_ii(c_ii), .c_j(c_j), .c_mi(c_mi), .c_oi(c_oi), .c_ro(c_ro), .c_zi(c_zi),
      .c_zo(c_zo), .c_next(c_next)
   );

   always #5 clk = ~clk;

   // {ai,ao,bi,ci,co,eo,ii,j,mi,oi,ro,zi,zo,next}
   wire [13:0] ctrl = {c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_ii, c_j, c_mi, c_oi, c_ro, c_zi, c_zo, c_next};

   int n_checks = 0;
   int n_fail   = 0;
   int m_cyc    = 0;
   int obs_cyc, obs_state;
   logic [13:0] obs_ctrl;
   logic [8:0]  obs_alu;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction programs: states from cycle 2 onward; past the end of a list the state is NEXT.
   function automatic int m_state(input int op, input int cyc);
      int rest[$];
      rest.delete();
      case (op)
         1:  rest = '{0, 2, 3, 4, 9};
         2:  rest = '{0, 2, 3, 5, 6, 9};
         3:  rest = '{7, 9};
         4:  rest = '{0, 8, 9};
         15: rest = '{10};
`ifdef ALU_SUB_EN
         5:  rest = '{0, 2, 3, 5, 11, 9};
`endif
         default: ;
      endcase
      if (cyc < 2) return cyc;
      if (cyc - 2 < rest.size()) return rest[cyc - 2];
      return 9;
   endfunction

   function automatic logic [13:0] m_ctrl(input int s, input bit in_reset);
      logic [13:0] v;
      v     = '0;
      v[13] = (s == 4) || (s == 6) || (s == 11);
      v[12] = (s == 7);
      v[11] = (s == 5);
      v[10] = (s == 1) || (s == 2) || (s == 8);
      v[9]  = (s == 0);
      v[8]  = (s == 6) || (s == 11);
      v[7]  = (s == 1);
      v[6]  = (s == 8);
      v[5]  = (s == 0) || (s == 3);
      v[4]  = (s == 7);
      v[3]  = (s == 1) || (s == 2) || (s == 8) || (s == 4) || (s == 5);
      v[2]  = (s == 2);
      v[1]  = (s == 3);
      v[0]  = (s == 9) || in_reset;
      return v;
   endfunction

   function automatic logic [31:0] m_alu(input int s, input int a, input int b, input int ci);
      if (s == 11) return (a + 256 - b) % 512;
      return a + b + ci;
   endfunction

   // One clock: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step(input logic r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
      int s;
      @(negedge clk);
      run = r; opcode = op; a_in = a; b_in = b; cin = ci;
      #1;
      s = m_state(int'(op), m_cyc);
      check("cycle", 32'(cycle), m_cyc);
      check("state", 32'(state), s);
      check("halted", 32'(halted), 32'(s == 10));
      check("ctrl", 32'(ctrl), 32'(m_ctrl(s, 1'b0)));
      check("alu", 32'({cout, alu_out}), m_alu(s, int'(a), int'(b), int'(ci)));
      check("bus_excl", 32'($countones({c_ao, c_co, c_eo, c_ro, c_zo}) <= 1), 32'd1);
      obs_cyc = int'(cycle); obs_state = int'(state); obs_ctrl = ctrl; obs_alu = {cout, alu_out};
      @(posedge clk);
      if (r) begin
         if (s == 9) m_cyc = 0;
         else if (s != 10) m_cyc = (m_cyc + 1) % 16;
      end
   endtask

   // Asynchronous reset pulse; released with run=0 so the first edge afterwards holds cycle 0.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; run = 1'b1;
      #1;
      check("rst_cycle", 32'(cycle), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_ctrl", 32'(ctrl), 32'(m_ctrl(0, 1'b1)));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_cycle", 32'(cycle), 32'd0);
         check("rst_hold_next", 32'(c_next), 32'd1);
      end
      @(negedge clk);
      reset = 1'b1; run = 1'b0;
      m_cyc = 0;
   endtask

   initial begin
      int lda_exp[7];
      int halt_run;
      logic [3:0] op;
      logic [3:0] picks[8];
      lda_exp = '{0, 1, 0, 2, 3, 4, 9};
      picks   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15, 4'd5, 4'd0};

      do_reset();

      // LDA walk-through
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 4'd1, 8'h12, 8'h34, 1'b0);
         check("lda_seq", 32'(obs_state), 32'(lda_exp[i]));
         check("lda_ai", 32'(obs_ctrl[13]), 32'(i == 5));
      end
      check("lda_wrap", 32'(m_cyc), 32'd0);

      // ADD with both operand sets
      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) begin
            if (k == 0) step(1'b1, 4'd2, 8'h7F, 8'h01, 1'b0);
            else        step(1'b1, 4'd2, 8'hFF, 8'h01, 1'b1);
            if (i == 6) begin
               check("add_sum", 32'(obs_alu), (k == 0) ? 32'h080 : 32'h101);
               check("add_ai_eo", 32'({obs_ctrl[13], obs_ctrl[8]}), 32'd3);
            end
         end
      end

      // run gating at cycle 3 of LDA
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 4'd1, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'd1, 8'h00, 8'h00, 1'b0);
         check("gate_cycle", 32'(obs_cyc), 32'd3);
         check("gate_ctrl", 32'(obs_ctrl), 32'h040C);
      end

      // HLT sticks for 20 clocks, then reset clears it
      do_reset();
      for (int i = 0; i < 23; i++) begin
         step(1'b1, 4'd15, 8'h00, 8'h00, 1'b0);
         if (i >= 2) begin
            check("hlt_cycle", 32'(obs_cyc), 32'd2);
            check("hlt_flag", 32'(obs_ctrl == 14'd0 && obs_state == 10), 32'd1);
         end
      end
      do_reset();

      // opcode 5
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'd5, 8'h05, 8'h07, 1'b1);
`ifdef ALU_SUB_EN
         if (i == 6) begin
            check("sub_state", 32'(obs_state), 32'd11);
            check("sub_result", 32'(obs_alu), 32'h0FE);
         end
`else
         if (i == 2) check("op5_undef", 32'(obs_state), 32'd9);
`endif
      end

      // randomized traffic
      op = 4'd1;
      halt_run = 0;
      for (int n = 0; n < 3000; n++) begin
         if (m_cyc == 0 || $urandom_range(19) == 0) begin
            if ($urandom_range(7) == 0) op = 4'($urandom);
            else op = picks[$urandom_range(7)];
         end
         if (m_state(int'(op), m_cyc) == 10) halt_run++;
         if (halt_run > 4 || $urandom_range(299) == 0) begin
            do_reset();
            halt_run = 0;
         end
         step(($urandom_range(3) != 0), op, 8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
